// File: rtl/down_counter_timer.sv
// down_counter_timer: programmable down-counting timer.
// Loads a value on start, counts down to zero and pulses tc for one cycle on
// expiry. With auto_reload set it reloads the captured value and keeps
// running, acting as a periodic tick generator.
module down_counter_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             auto_reload,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] reload_reg;

    // Timer FSM: abort > start > pause > decrement, all outputs registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            count      <= '0;
            reload_reg <= '0;
            busy       <= 1'b0;
            tc         <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (abort) begin
                count <= '0;
                state <= IDLE;
                busy  <= 1'b0;
            end else if (start) begin
                count      <= load_val;
                reload_reg <= load_val;
                if (load_val != '0) begin
                    state <= RUN;
                    busy  <= 1'b1;
                end else begin
                    // zero load expires immediately without entering RUN
                    state <= IDLE;
                    busy  <= 1'b0;
                    tc    <= 1'b1;
                end
            end else if (state == RUN && !pause) begin
                if (count == WIDTH'(1)) begin
                    tc <= 1'b1;
                    if (auto_reload) begin
                        count <= reload_reg;
                    end else begin
                        count <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end else begin
                    count <= count - WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer: directed steps push the
// expected post-edge outputs into a scoreboard queue, which is popped and
// compared once the DUT has produced them.
module tb_down_counter_timer;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] load_val;
    logic             auto_reload;
    logic             pause;
    logic             abort;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             tc;

    typedef struct {
        logic [WIDTH-1:0] count;
        logic             busy;
        logic             tc;
        string            tag;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    down_counter_timer #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .load_val    (load_val),
        .auto_reload (auto_reload),
        .pause       (pause),
        .abort       (abort),
        .count       (count),
        .busy        (busy),
        .tc          (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input logic [WIDTH-1:0] c, input logic b,
                            input logic t, input string tag);
        exp_t e;
        e.count = c;
        e.busy  = b;
        e.tc    = t;
        e.tag   = tag;
        exp_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty got=0 entries exp>=1");
            return;
        end
        e = exp_q.pop_front();
        total++;
        assert (count === e.count) else begin
            bad++;
            $error("FAIL %s count got=%0d exp=%0d", e.tag, count, e.count);
        end
        total++;
        assert (busy === e.busy) else begin
            bad++;
            $error("FAIL %s busy got=%0b exp=%0b", e.tag, busy, e.busy);
        end
        total++;
        assert (tc === e.tc) else begin
            bad++;
            $error("FAIL %s tc got=%0b exp=%0b", e.tag, tc, e.tc);
        end
    endtask

    // drive inputs, expect outputs after the next rising edge
    task automatic step(input logic st, input logic [WIDTH-1:0] lv,
                        input logic ar, input logic pa, input logic ab,
                        input logic [WIDTH-1:0] ec, input logic eb,
                        input logic et, input string tag);
        start       = st;
        load_val    = lv;
        auto_reload = ar;
        pause       = pa;
        abort       = ab;
        push_exp(ec, eb, et, tag);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        load_val = '0;
        auto_reload = 1'b0;
        pause = 1'b0;
        abort = 1'b0;

        // reset state
        #1;
        push_exp(0, 0, 0, "reset");
        pop_check();
        repeat (2) @(posedge clk);
        #1;
        push_exp(0, 0, 0, "reset_hold");
        pop_check();
        rst = 1'b1;

        // one-shot load 5
        step(1, 5, 0, 0, 0, 5, 1, 0, "os_load");
        step(0, 0, 0, 0, 0, 4, 1, 0, "os_4");
        step(0, 0, 0, 0, 0, 3, 1, 0, "os_3");
        step(0, 0, 0, 0, 0, 2, 1, 0, "os_2");
        step(0, 0, 0, 0, 0, 1, 1, 0, "os_1");
        step(0, 0, 0, 0, 0, 0, 0, 1, "os_expire");
        step(0, 0, 0, 0, 0, 0, 0, 0, "os_after");
        step(0, 0, 0, 0, 0, 0, 0, 0, "os_idle");

        // periodic load 3
        step(1, 3, 1, 0, 0, 3, 1, 0, "per_load");
        for (int p = 0; p < 3; p++) begin
            step(0, 0, 1, 0, 0, 2, 1, 0, "per_2");
            step(0, 0, 1, 0, 0, 1, 1, 0, "per_1");
            step(0, 0, 1, 0, 0, 3, 1, 1, "per_tick");
        end
        step(0, 0, 0, 0, 0, 2, 1, 0, "per_off_2");
        step(0, 0, 0, 0, 0, 1, 1, 0, "per_off_1");
        step(0, 0, 0, 0, 0, 0, 0, 1, "per_off_expire");
        step(0, 0, 0, 0, 0, 0, 0, 0, "per_off_idle");

        // pause at count 4
        step(1, 6, 0, 0, 0, 6, 1, 0, "pa_load");
        step(0, 0, 0, 0, 0, 5, 1, 0, "pa_5");
        step(0, 0, 0, 0, 0, 4, 1, 0, "pa_4");
        for (int p = 0; p < 4; p++)
            step(0, 0, 0, 1, 0, 4, 1, 0, "pa_hold");
        step(0, 0, 0, 0, 0, 3, 1, 0, "pa_3");
        step(0, 0, 0, 0, 0, 2, 1, 0, "pa_2");
        step(0, 0, 0, 0, 0, 1, 1, 0, "pa_1");
        step(0, 0, 0, 0, 0, 0, 0, 1, "pa_expire");
        step(0, 0, 0, 0, 0, 0, 0, 0, "pa_after");

        // abort at count 2
        step(1, 4, 0, 0, 0, 4, 1, 0, "ab_load");
        step(0, 0, 0, 0, 0, 3, 1, 0, "ab_3");
        step(0, 0, 0, 0, 0, 2, 1, 0, "ab_2");
        step(0, 0, 0, 0, 1, 0, 0, 0, "ab_abort");
        step(0, 0, 0, 0, 0, 0, 0, 0, "ab_idle1");
        step(0, 0, 0, 0, 0, 0, 0, 0, "ab_idle2");

        // restart mid-run
        step(1, 9, 0, 0, 0, 9, 1, 0, "rs_load9");
        step(0, 0, 0, 0, 0, 8, 1, 0, "rs_8");
        step(0, 0, 0, 0, 0, 7, 1, 0, "rs_7");
        step(1, 2, 0, 0, 0, 2, 1, 0, "rs_load2");
        step(0, 0, 0, 0, 0, 1, 1, 0, "rs_1");
        step(0, 0, 0, 0, 0, 0, 0, 1, "rs_expire");
        step(0, 0, 0, 0, 0, 0, 0, 0, "rs_after");

        // zero load: immediate expiry
        step(1, 0, 0, 0, 0, 0, 0, 1, "z_load");
        step(0, 0, 0, 0, 0, 0, 0, 0, "z_after");

        // full-scale load: no wrap
        step(1, 15, 0, 0, 0, 15, 1, 0, "f_load");
        for (int k = 14; k >= 1; k--)
            step(0, 0, 0, 0, 0, WIDTH'(k), 1, 0, "f_dec");
        step(0, 0, 0, 0, 0, 0, 0, 1, "f_expire");
        step(0, 0, 0, 0, 0, 0, 0, 0, "f_after");

        // load 1 periodic: tc every cycle
        step(1, 1, 1, 0, 0, 1, 1, 0, "one_load");
        for (int p = 0; p < 3; p++)
            step(0, 0, 1, 0, 0, 1, 1, 1, "one_tick");
        step(0, 0, 1, 0, 1, 0, 0, 0, "one_abort");

        // start held high keeps reloading
        for (int p = 0; p < 3; p++)
            step(1, 5, 0, 0, 0, 5, 1, 0, "hold_start");
        step(0, 0, 0, 0, 0, 4, 1, 0, "hold_release");
        step(0, 0, 0, 0, 1, 0, 0, 0, "hold_abort");

        // async reset mid-run in auto-reload mode
        step(1, 5, 1, 0, 0, 5, 1, 0, "rr_load");
        step(0, 0, 1, 0, 0, 4, 1, 0, "rr_4");
        step(0, 0, 1, 0, 0, 3, 1, 0, "rr_3");
        #2;
        rst = 1'b0;
        #1;
        push_exp(0, 0, 0, "rr_async");
        pop_check();
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(0, 0, 1, 0, 0, 0, 0, 0, "rr_idle1");
        step(0, 0, 1, 0, 0, 0, 0, 0, "rr_idle2");

        // reset clears a live tc pulse
        step(1, 0, 0, 0, 0, 0, 0, 1, "rt_tc");
        start = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        push_exp(0, 0, 0, "rt_async");
        pop_check();
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, 0, "rt_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/down_counter_timer.md
# down_counter_timer

Programmable down-counting timer. It is the counterpart to the free-running 4-bit up-counter: instead of counting up from reset, it loads a value and counts down to zero. Each expiry produces a one-cycle terminal-count pulse, and an optional auto-reload mode makes it a periodic tick generator. It sits beside the up-counter in the timing/counter blocks and feeds event-scheduling logic that needs "N cycles from now" or "every N cycles".

## Interface
- WIDTH, 4: width of the count path, load value and reload register.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  asynchronous, active-low reset; the block is in reset while rst=0.
- start  input  1  level sampled each cycle; captures load_val and begins counting.
- load_val  input  WIDTH  initial/reload value, sampled only when start=1.
- auto_reload  input  1  level; sampled when count leaves 1; 1 = periodic, 0 = one-shot.
- pause  input  1  level; 1 holds count while running.
- abort  input  1  level; 1 stops counting immediately, with no tc.
- count  output  WIDTH  current count value, registered.
- busy  output  1  1 while in RUN state, registered.
- tc  output  1  terminal-count pulse, exactly one cycle wide, registered.

## Operation
- States:
  - IDLE: busy=0, count holds its value.
  - RUN: busy=1.
- Internal register reload_reg (WIDTH bits) captures load_val on every accepted start.
- Priority per clock edge: abort > start > pause > decrement.
- abort=1 (any state): count<=0, state<=IDLE, tc<=0; reload_reg unchanged.
- start=1 (any state, abort=0): count<=load_val, reload_reg<=load_val.
  - load_val≠0: state<=RUN.
  - load_val=0: state<=IDLE, tc<=1 for one cycle (immediate expiry).
  - start in RUN restarts the timer; no tc for the interrupted period.
- RUN, pause=1: count and state hold, tc<=0.
- RUN, pause=0, count>1: count<=count-1, tc<=0.
- RUN, pause=0, count==1: tc<=1.
  - auto_reload=1: count<=reload_reg, stay in RUN.
  - auto_reload=0: count<=0, state<=IDLE.
- tc is 0 on every edge not listed above.
- Decrement is modulo-2^WIDTH unsigned, but count is never decremented from 0 in RUN (not reachable).
- auto_reload is sampled only on the count==1 edge; changing it mid-period has no effect until then.
- No input handshake: start is accepted on every edge where it is 1 and abort=0. Holding start high keeps reloading, so count never decrements.

## Timing
- Reset (rst=0): count=0, busy=0, tc=0, reload_reg=0, state=IDLE, all asynchronously. The first edge after rst rises is a normal edge.
- Start sampled at edge E with load_val=N (N≥1):
  - After E: count=N, busy=1.
  - After E+k: count=N-k, for k<N with no pause.
  - After E+N: tc=1 for exactly one cycle.
  - Each paused cycle delays expiry by exactly one cycle.
- One-shot: busy falls on the same edge tc rises. tc=0 and count=0 after the next edge.
- Auto-reload: tc pulses every N cycles; count sequence N, N-1, …, 1, N, …; busy stays 1.
- load_val=1 with auto_reload=1: tc is high every cycle and count stays 1.
- Reset asserted mid-run forces the reset values immediately. tc never stretches across reset.

## Test plan
- Reset then one-shot: rst=0 for 2 cycles, then rst=1; start=1 for one cycle with load_val=5, auto_reload=0 -> count 5,4,3,2,1,0; tc=1 exactly on the cycle count=0, 5 edges after start; busy 1→0 on that edge; count stays 0 afterwards.
- Periodic: load_val=3, auto_reload=1, run 10 cycles -> count 3,2,1,3,2,1,…; tc pulses every 3rd cycle, 3 pulses total; busy held at 1; then auto_reload=0 -> expires at 0 after the current period.
- Pause/abort: load_val=6, pause=1 for 4 cycles at count=4 -> count holds at 4, tc first appears 10 edges after start. Separate run: abort at count=2 -> count=0, busy=0, no tc.
- Restart and edge loads: start with load_val=9, then start again at count=7 with load_val=2 -> count 2,1,0, tc once, no tc for the first period. load_val=0 -> immediate one-cycle tc, busy stays 0. load_val=15 -> 15 decrements with no wrap.
- Reset mid-operation: rst=0 asynchronously at count=3 in auto-reload mode -> count=0, busy=0, tc=0 before the next edge. After rst=1, no activity until start.
